// File: rtl/wb_pipe_std_bridge.sv
// Wishbone B4 pipelined master to classic slave bridge: requests are queued in a
// DEPTH-entry FIFO and replayed in order. Define WB_BRIDGE_ERR_EN for s_err/m_err.
module wb_pipe_std_bridge #(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m_cyc,
  input  logic            m_stb,
  input  logic            m_we,
  input  logic [AW-1:0]   m_adr,
  input  logic [DW/8-1:0] m_sel,
  input  logic [DW-1:0]   m_dat_i,
  output logic [DW-1:0]   m_dat_o,
  output logic            m_ack,
  output logic            m_stall,
  output logic            s_cyc,
  output logic            s_stb,
  output logic            s_we,
  output logic [AW-1:0]   s_adr,
  output logic [DW/8-1:0] s_sel,
  output logic [DW-1:0]   s_dat_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack
`ifdef WB_BRIDGE_ERR_EN
  ,
  input  logic            s_err,
  output logic            m_err
`endif
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    REQ
  } state_t;

  state_t state, state_nxt;

  logic          we_mem  [DEPTH];
  logic [AW-1:0] adr_mem [DEPTH];
  logic [SW-1:0] sel_mem [DEPTH];
  logic [DW-1:0] dat_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, err_in, term_ok;

`ifdef WB_BRIDGE_ERR_EN
  assign err_in = s_err;
`else
  assign err_in = 1'b0;
`endif

  assign m_stall = (count == FULL);
  assign push    = m_cyc & m_stb & ~m_stall;
  assign s_stb   = m_cyc & (state == REQ);
  assign s_cyc   = m_cyc & ((state == REQ) | (count != '0));
  assign pop     = s_stb & (s_ack | err_in);
  assign term_ok = s_stb & s_ack & ~err_in;

  // Head fields are forced to zero while no strobe is presented.
  assign s_we    = s_stb & we_mem[rd_ptr];
  assign s_adr   = s_stb ? adr_mem[rd_ptr] : '0;
  assign s_sel   = s_stb ? sel_mem[rd_ptr] : '0;
  assign s_dat_o = s_stb ? dat_mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      we_mem[wr_ptr]  <= m_we;
      adr_mem[wr_ptr] <= m_adr;
      sel_mem[wr_ptr] <= m_sel;
      dat_mem[wr_ptr] <= m_dat_i;
    end
  end

  // An incoming push also wakes IDLE so the strobe appears one cycle after accept.
  always_comb begin
    state_nxt = state;
    if (!m_cyc) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (push || (count != '0)) state_nxt = REQ;
        REQ:  if (pop && !push && (count == CW'(1))) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      m_ack   <= 1'b0;
      m_dat_o <= '0;
`ifdef WB_BRIDGE_ERR_EN
      m_err   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      m_ack <= term_ok;
`ifdef WB_BRIDGE_ERR_EN
      m_err <= s_stb & s_err;
`endif
      if (term_ok && !s_we) m_dat_o <= s_dat_i;
      if (!m_cyc) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe_std_bridge.sv
// Self-checking bench for wb_pipe_std_bridge: randomized traffic against a queue/memory
// reference model plus directed latency, abort and reset scenarios.
module tb_wb_pipe_std_bridge;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] rdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0;
  logic [31:0] m_adr = '0, m_dat_i = '0, s_dat_i = '0;
  logic [3:0]  m_sel = '0;
  logic [31:0] m_dat_o, s_adr, s_dat_o;
  logic [3:0]  s_sel;
  logic        m_ack, m_stall, s_cyc, s_stb, s_we;
  logic        s_ack = 1'b0;
`ifdef WB_BRIDGE_ERR_EN
  logic        s_err = 1'b0;
  logic        m_err;
`endif

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rd;
  logic [31:0] ref_mem [16];
  logic [31:0] slv_mem [16];

  always #5 clk = ~clk;

  wb_pipe_std_bridge #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_ack(m_ack), .m_stall(m_stall),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack(s_ack)
`ifdef WB_BRIDGE_ERR_EN
    , .s_err(s_err), .m_err(m_err)
`endif
  );

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b0; m_cyc = 1'b1; m_stb = 1'b0; s_ack = 1'b1;
    #1;
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL rst_m_ack: got %b expected 0", m_ack); end
    checks++; if (m_dat_o !== 32'h0) begin errors++; $display("FAIL rst_m_dat_o: got %h expected 0", m_dat_o); end
    checks++; if (m_stall !== 1'b0) begin errors++; $display("FAIL rst_m_stall: got %b expected 0", m_stall); end
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL rst_s_stb: got %b expected 0", s_stb); end
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL rst_s_cyc: got %b expected 0", s_cyc); end
`ifdef WB_BRIDGE_ERR_EN
    checks++; if (m_err !== 1'b0) begin errors++; $display("FAIL rst_m_err: got %b expected 0", m_err); end
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1; m_cyc = 1'b0; s_ack = 1'b0;
    exp_rd = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h10; m_sel = 4'hF;
    #1;
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL sr_stb_T: got %b expected 0", s_stb); end
    @(negedge clk);
    m_stb = 1'b0;
    #1;
    checks++; if (s_stb !== 1'b1 || s_adr !== 32'h10 || s_we !== 1'b0) begin
      errors++; $display("FAIL sr_stb_T1: got stb=%b adr=%h we=%b expected stb=1 adr=00000010 we=0", s_stb, s_adr, s_we);
    end
    s_ack = 1'b1; s_dat_i = 32'hCAFE0001;
    @(negedge clk);
    checks++; if (m_ack !== 1'b1 || m_dat_o !== 32'hCAFE0001) begin
      errors++; $display("FAIL sr_ack_T2: got ack=%b dat=%h expected ack=1 dat=cafe0001", m_ack, m_dat_o);
    end
    exp_rd = 32'hCAFE0001;
    s_ack = 1'b0;
    #1;
    checks++; if (s_stb !== 1'b0) begin errors++; $display("FAIL sr_stb_done: got %b expected 0", s_stb); end
    @(negedge clk);
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL sr_single_pulse: got %b expected 0", m_ack); end
    m_cyc = 1'b0;
  endtask

  task automatic run_traffic(input int n, input int ws_lo, input int ws_hi, input int gap_pct,
                             input bit writes_only, output int first_ack, output int last_ack,
                             output bit saw_stall);
    req_t exp_q[$];
    req_t slv_q[$];
    req_t cur, e;
    int   issued, acked, cyc, wc, ws_cur, model_cnt, budget, idx;
    bit   have_cur, push, pop;
    issued = 0; acked = 0; cyc = 0; wc = 0; model_cnt = 0; have_cur = 0;
    first_ack = -1; last_ack = -1; saw_stall = 0; cur = '0;
    budget = n * 12 + 40;
    ws_cur = int'($urandom_range(ws_hi, ws_lo));
    while (acked < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (m_ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL spurious_ack: got m_ack=1 expected 0 with nothing pending");
        end else begin
          e = exp_q.pop_front();
          if (!e.we) exp_rd = e.rdata;
          acked++;
          if (first_ack < 0) first_ack = cyc;
          last_ack = cyc;
        end
      end
      checks++; if (m_dat_o !== exp_rd) begin errors++; $display("FAIL rdata: got %h expected %h", m_dat_o, exp_rd); end
      checks++; if (m_stall !== (model_cnt == DEPTH)) begin
        errors++; $display("FAIL stall: got %b expected %b (queued %0d)", m_stall, model_cnt == DEPTH, model_cnt);
      end
      if (m_stall === 1'b1) saw_stall = 1;
      if (!have_cur && issued < n && int'($urandom_range(99)) >= gap_pct) begin
        cur.we    = writes_only ? 1'b1 : 1'($urandom_range(1));
        cur.adr   = {26'd0, 4'($urandom_range(15)), 2'b00};
        cur.sel   = cur.we ? 4'($urandom_range(15)) : 4'hF;
        cur.dat   = $urandom;
        cur.rdata = '0;
        have_cur  = 1;
      end
      m_cyc = 1'b1; m_stb = have_cur; m_we = cur.we; m_adr = cur.adr; m_sel = cur.sel; m_dat_i = cur.dat;
      push = have_cur && (m_stall === 1'b0);
      if (push) begin
        idx = int'(cur.adr[5:2]);
        if (cur.we) ref_mem[idx] = merge(ref_mem[idx], cur.dat, cur.sel);
        else cur.rdata = ref_mem[idx];
        exp_q.push_back(cur);
        slv_q.push_back(cur);
        issued++;
        have_cur = 0;
      end
      #1;
      checks++; if (s_stb !== (model_cnt != 0)) begin
        errors++; $display("FAIL s_stb: got %b expected %b", s_stb, model_cnt != 0);
      end
      pop = 0;
      if (s_stb === 1'b1 && slv_q.size() > 0) begin
        e = slv_q[0];
        checks++;
        if (s_we !== e.we || s_adr !== e.adr || s_sel !== e.sel || (e.we && s_dat_o !== e.dat)) begin
          errors++; $display("FAIL head: got we=%b adr=%h sel=%h dat=%h expected we=%b adr=%h sel=%h dat=%h",
                             s_we, s_adr, s_sel, s_dat_o, e.we, e.adr, e.sel, e.dat);
        end
        if (wc >= ws_cur) begin
          s_ack = 1'b1;
          idx = int'(s_adr[5:2]);
          if (s_we) begin
            slv_mem[idx] = merge(slv_mem[idx], s_dat_o, s_sel);
            s_dat_i = $urandom;
          end else begin
            s_dat_i = slv_mem[idx];
          end
          e = slv_q.pop_front();
          pop = 1; wc = 0;
          ws_cur = int'($urandom_range(ws_hi, ws_lo));
        end else begin
          s_ack = 1'b0;
          wc++;
        end
      end else begin
        s_ack = 1'($urandom_range(1));
        s_dat_i = $urandom;
      end
      model_cnt = model_cnt + int'(push) - int'(pop);
    end
    checks++; if (acked != n) begin errors++; $display("FAIL ack_count: got %0d expected %0d", acked, n); end
    m_stb = 1'b0; s_ack = 1'b0;
    @(negedge clk);
    checks++; if (m_ack !== 1'b0) begin errors++; $display("FAIL extra_ack: got %b expected 0", m_ack); end
    m_cyc = 1'b0;
  endtask

  task automatic test_back_to_back();
    int  fa, la;
    bit  st;
    run_traffic(8, 0, 0, 0, 1'b0, fa, la, st);
    checks++; if (fa != 3) begin errors++; $display("FAIL b2b_latency: got cycle %0d expected 3", fa); end
    checks++; if (la - fa != 7) begin errors++; $display("FAIL b2b_rate: got span %0d expected 7", la - fa); end
  endtask

  task automatic test_burst_writes();
    int  fa, la;
    bit  st;
    run_traffic(6, 2, 2, 0, 1'b1, fa, la, st);
    checks++; if (st !== 1'b1) begin errors++; $display("FAIL burst_stall_seen: got %b expected 1", st); end
  endtask

  task automatic test_random();
    int  fa, la;
    bit  st;
    for (int r = 0; r < 3; r++) run_traffic(20, 0, 3, 30, 1'b0, fa, la, st);
    checks++;
    for (int i = 0; i < 16; i++) if (slv_mem[i] !== ref_mem[i]) begin
      errors++; $display("FAIL mem_%0d: got %h expected %h", i, slv_mem[i], ref_mem[i]);
    end
  endtask

  task automatic test_abort();
    int acks;
    acks = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = 32'(4 * (i + 1));
      #1;
      if (i == 1) begin
        checks++; if (s_stb !== 1'b1 || s_adr !== 32'h4) begin
          errors++; $display("FAIL abort_head: got stb=%b adr=%h expected stb=1 adr=00000004", s_stb, s_adr);
        end
        s_ack = 1'b0;
      end
      if (i == 2) begin s_ack = 1'b1; s_dat_i = 32'h5A5A1234; end
    end
    @(negedge clk);
    if (m_ack === 1'b1) acks++;
    checks++; if (m_dat_o !== 32'h5A5A1234) begin errors++; $display("FAIL abort_rdata: got %h expected 5a5a1234", m_dat_o); end
    exp_rd = 32'h5A5A1234;
    m_stb = 1'b0; m_cyc = 1'b0;
    #1;
    checks++; if (s_cyc !== 1'b0 || s_stb !== 1'b0) begin
      errors++; $display("FAIL abort_immediate: got cyc=%b stb=%b expected 0 0", s_cyc, s_stb);
    end
    s_ack = 1'b1; s_dat_i = 32'hDEAD0000;
    @(negedge clk);
    if (m_ack === 1'b1) acks++;
    s_ack = 1'b0; m_cyc = 1'b1;
    #1;
    checks++; if (s_cyc !== 1'b0 || m_stall !== 1'b0) begin
      errors++; $display("FAIL abort_flushed: got cyc=%b stall=%b expected 0 0", s_cyc, m_stall);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (m_ack === 1'b1) acks++;
    end
    checks++; if (acks != 1) begin errors++; $display("FAIL abort_acks: got %0d expected 1", acks); end
    checks++; if (m_dat_o !== exp_rd) begin errors++; $display("FAIL abort_hold: got %h expected %h", m_dat_o, exp_rd); end
    m_cyc = 1'b0;
  endtask

`ifdef WB_BRIDGE_ERR_EN
  task automatic test_err();
    logic [2:0] exp_ack, exp_err;
    logic [31:0] exp_d [3];
    exp_ack = 3'b101; exp_err = 3'b010;
    exp_d[0] = 32'h11111111; exp_d[1] = 32'h11111111; exp_d[2] = 32'h33333333;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c >= 2 && c <= 4) begin
        checks++;
        if (m_ack !== exp_ack[c-2] || m_err !== exp_err[c-2] || m_dat_o !== exp_d[c-2]) begin
          errors++; $display("FAIL err_seq_%0d: got ack=%b err=%b dat=%h expected ack=%b err=%b dat=%h",
                             c, m_ack, m_err, m_dat_o, exp_ack[c-2], exp_err[c-2], exp_d[c-2]);
        end
      end
      m_cyc = 1'b1; m_stb = (c < 3); m_we = 1'b0; m_sel = 4'hF; m_adr = 32'(4 * (c + 1));
      s_ack = (c == 1) || (c == 3); s_err = (c == 2);
      s_dat_i = (c == 1) ? 32'h11111111 : (c == 3) ? 32'h33333333 : 32'hBAD0BAD0;
    end
    exp_rd = 32'h33333333;
    s_ack = 1'b0; s_err = 1'b0; m_cyc = 1'b0;
  endtask
`endif

  task automatic test_reset_midburst();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_sel = 4'hF; m_adr = 32'(32 + 4 * i);
      s_ack = 1'b0;
    end
    @(negedge clk);
    m_stb = 1'b0;
    #1;
    checks++; if (s_stb !== 1'b1 || s_adr !== 32'h20) begin
      errors++; $display("FAIL pre_reset_head: got stb=%b adr=%h expected stb=1 adr=00000020", s_stb, s_adr);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (m_ack !== 1'b0 || m_dat_o !== 32'h0 || m_stall !== 1'b0 || s_cyc !== 1'b0 || s_stb !== 1'b0 ||
        s_we !== 1'b0 || s_adr !== 32'h0 || s_sel !== 4'h0 || s_dat_o !== 32'h0) begin
      errors++; $display("FAIL async_reset: got ack=%b dat=%h stall=%b cyc=%b stb=%b we=%b adr=%h sel=%h wdat=%h expected all 0",
                         m_ack, m_dat_o, m_stall, s_cyc, s_stb, s_we, s_adr, s_sel, s_dat_o);
    end
    exp_rd = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL post_reset_empty: got %b expected 0", s_cyc); end
    m_cyc = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    for (int i = 0; i < 16; i++) begin
      v = $urandom;
      ref_mem[i] = v;
      slv_mem[i] = v;
    end
    test_reset();
    test_single_read();
    test_back_to_back();
    test_burst_writes();
    test_random();
    test_abort();
`ifdef WB_BRIDGE_ERR_EN
    test_err();
`endif
    test_reset_midburst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
